// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift-register sequencer with load, enable, wrap pulse,
// and illegal-state self-correction with a sticky error flag.
//
// Parameters:
//   WIDTH       pattern width (2..64)
//   RESET_VALUE reset and correction target; one-hot and a Johnson code
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   en         step enable
//   dir        1 = shift toward bit 0, 0 = shift toward MSB
//   johnson    0 = ring (one-hot) mode, 1 = Johnson (twisted-ring) mode
//   load       synchronous parallel load strobe (beats en)
//   load_value value captured on load, not checked
//   count      current pattern (registered)
//   wrap       one-cycle pulse while count re-enters RESET_VALUE
//   error      sticky flag set by a correction step, cleared by load/reset
module ring_johnson_counter #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             johnson,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             error
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-2:0] EDGE_ONE = (WIDTH-1)'(1);

    logic [WIDTH-2:0] edges;
    logic             ring_ok;
    logic             john_ok;
    logic             legal;
    logic [WIDTH-1:0] ring_next;
    logic [WIDTH-1:0] john_next;
    logic [WIDTH-1:0] step_next;

    // A Johnson code has at most one boundary between adjacent bits; a ring
    // pattern has exactly one bit set. x & (x-1) clears the lowest set bit,
    // so it is zero only when x has at most one bit set.
    always_comb begin
        edges     = count[WIDTH-1:1] ^ count[WIDTH-2:0];
        ring_ok   = (count != '0) && ((count & (count - ONE)) == '0);
        john_ok   = (edges & (edges - EDGE_ONE)) == '0;
        legal     = johnson ? john_ok : ring_ok;
        ring_next = dir ? {count[0], count[WIDTH-1:1]}
                        : {count[WIDTH-2:0], count[WIDTH-1]};
        john_next = dir ? {~count[0], count[WIDTH-1:1]}
                        : {count[WIDTH-2:0], ~count[WIDTH-1]};
        step_next = johnson ? john_next : ring_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
            wrap  <= 1'b0;
            error <= 1'b0;
        end else if (load) begin
            count <= load_value;
            wrap  <= 1'b0;
            error <= 1'b0;
        end else if (en) begin
            if (legal) begin
                count <= step_next;
                wrap  <= (step_next == RESET_VALUE);
            end else begin
                // Correction step: no shift, jump back to a known state.
                count <= RESET_VALUE;
                wrap  <= 1'b0;
                error <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
